// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [63:0] pend, pend_next;
    logic        pend_wr, pend_wr_next;
    logic [31:0] hi_next, lo_next;

    // Op[0] selects the unsigned flavour for both multiply and divide
    logic        is_signed;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    assign is_signed = ~Op[0];
    assign mul_a     = {{32{A[31] & is_signed}}, A};
    assign mul_b     = {{32{B[31] & is_signed}}, B};
    assign product   = mul_a * mul_b;

    // Divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    assign a_neg  = A[31] & is_signed;
    assign b_neg  = B[31] & is_signed;
    assign a_mag  = a_neg ? (32'd0 - A) : A;
    assign b_mag  = b_neg ? (32'd0 - B) : B;
    assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_next   = state;
        count_next   = count;
        pend_next    = pend;
        pend_wr_next = pend_wr;
        hi_next      = HI;
        lo_next      = LO;
        case (state)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        3'b000, 3'b001: begin
                            state_next   = RUN;
                            count_next   = 4'(MULT_CYCLES);
                            pend_next    = product;
                            pend_wr_next = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_next   = RUN;
                            count_next   = 4'(DIV_CYCLES);
                            pend_next    = {rem, quo};
                            pend_wr_next = (B != 32'd0);
                        end
                        3'b100:  hi_next = A;
                        3'b101:  lo_next = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (count == 4'd1) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                    if (pend_wr) begin
                        hi_next = pend[63:32];
                        lo_next = pend[31:0];
                    end
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            pend    <= pend_next;
            pend_wr <= pend_wr_next;
            HI      <= hi_next;
            LO      <= lo_next;
        end
    end

    assign Busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_hi, exp_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural result of one accepted op; returns expected busy length
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        longint      sa, sb, q, r, p;
        logic [63:0] pu;
        n = 0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                exp_hi = p[63:32]; exp_lo = p[31:0]; n = 5;
            end
            3'd1: begin
                pu = 64'(a) * 64'(b);
                exp_hi = pu[63:32]; exp_lo = pu[31:0]; n = 5;
            end
            3'd2: begin
                n = 10;
                if (b != 0) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    q = sa / sb; r = sa % sb;
                    exp_lo = q[31:0]; exp_hi = r[31:0];
                end
            end
            3'd3: begin
                n = 10;
                if (b != 0) begin
                    exp_lo = a / b; exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Pulse Start for one cycle, scramble operands while busy, measure the busy run
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output bit hold_ok);
        logic [31:0] hi0, lo0;
        @(posedge clk); #1;
        hi0 = HI; lo0 = LO;
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        busy_cycles = 0;
        hold_ok = 1'b1;
        while (Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (HI !== hi0 || LO !== lo0) hold_ok = 1'b0;
            A = $urandom; B = $urandom; Op = 3'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; Start = 1'b0; A = '0; B = '0; Op = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_hi = 0; exp_lo = 0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    endtask

    task automatic test_directed;
        logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
        logic [31:0] as  [7] = '{32'd11, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h5678, 32'h80000000};
        logic [31:0] bs  [7] = '{32'hFFFFFD66, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        int n, bc; bit hold;
        for (int i = 0; i < 7; i++) begin
            model(ops[i], as[i], bs[i], n);
            run_op(ops[i], as[i], bs[i], bc, hold);
            checks++; if (bc != n) begin errors++; $display("FAIL dir%0d_busy got=%0d exp=%0d", i, bc, n); end
            checks++; if (!hold) begin errors++; $display("FAIL dir%0d_hold got=changed exp=held", i); end
            checks++; if (HI !== exp_hi) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, HI, exp_hi); end
            checks++; if (LO !== exp_lo) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, LO, exp_lo); end
        end
    endtask

    task automatic test_div_zero;
        int n, bc; bit hold;
        model(3'd4, 32'h1234, 0, n); run_op(3'd4, 32'h1234, 0, bc, hold);
        checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi got=%h exp=00001234", HI); end
        model(3'd5, 32'h5678, 0, n); run_op(3'd5, 32'h5678, 0, bc, hold);
        checks++; if (LO !== 32'h5678) begin errors++; $display("FAIL mtlo got=%h exp=00005678", LO); end
        checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mtlo_keep_hi got=%h exp=00001234", HI); end
        model(3'd2, 32'd99, 32'd0, n); run_op(3'd2, 32'd99, 32'd0, bc, hold);
        checks++; if (bc != 10) begin errors++; $display("FAIL divz_busy got=%0d exp=10", bc); end
        checks++; if (HI !== 32'h1234 || LO !== 32'h5678)
            begin errors++; $display("FAIL divz_hilo got=%h/%h exp=00001234/00005678", HI, LO); end
    endtask

    // Start mid-run (cycle 3) and in the last busy cycle must both be ignored
    task automatic test_busy_ignore;
        int bc;
        logic [31:0] ma [2] = '{32'd3, 32'd5};
        logic [31:0] mb [2] = '{32'd4, 32'd6};
        int          at [2] = '{3, 5};
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            Op = 3'd0; A = ma[k]; B = mb[k]; Start = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
            bc = 0;
            while (Busy === 1'b1 && bc < 40) begin
                bc++;
                if (bc == at[k]) begin Op = (k == 0) ? 3'd4 : 3'd5; A = 32'hDEAD; Start = 1'b1; end
                else Start = 1'b0;
                @(posedge clk); #1;
            end
            Start = 1'b0;
            exp_hi = 0; exp_lo = ma[k] * mb[k];
            checks++; if (bc != 5) begin errors++; $display("FAIL ign%0d_busy got=%0d exp=5", k, bc); end
            checks++; if (HI !== exp_hi) begin errors++; $display("FAIL ign%0d_hi got=%h exp=%h", k, HI, exp_hi); end
            checks++; if (LO !== exp_lo) begin errors++; $display("FAIL ign%0d_lo got=%h exp=%h", k, LO, exp_lo); end
            @(posedge clk); #1;
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ign%0d_queued got=%0b exp=0", k, Busy); end
        end
    endtask

    task automatic test_reset_mid;
        int n, bc; bit hold;
        model(3'd4, 32'h55, 0, n); run_op(3'd4, 32'h55, 0, bc, hold);
        @(posedge clk); #1;
        Op = 3'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_hi = 0; exp_lo = 0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", Busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0)
            begin errors++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", HI, LO); end
        repeat (15) @(posedge clk);
        #1;
        checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            begin errors++; $display("FAIL rstmid_late got=%0b %h/%h exp=0 0/0", Busy, HI, LO); end
    endtask

    task automatic test_random;
        int n, bc; bit hold;
        logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            model(op, a, b, n);
            run_op(op, a, b, bc, hold);
            checks++; if (bc != n) begin errors++; $display("FAIL rnd%0d_busy op=%0d got=%0d exp=%0d", i, op, bc, n); end
            checks++; if (!hold) begin errors++; $display("FAIL rnd%0d_hold op=%0d got=changed exp=held", i, op); end
            checks++; if (HI !== exp_hi || LO !== exp_lo)
                begin errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h", i, op, a, b, HI, LO, exp_hi, exp_lo); end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_zero;
        test_busy_ignore;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
